// File: rtl/code_inv_dec.sv
// Inverse 3-bit code decoder with a 2-entry output FIFO, a +1 mod 8 sequence
// checker and a saturating count of completed output handshakes.
module code_inv_dec #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_idx,
  output logic             out_seq_err,
  output logic [CNT_W-1:0] dec_count
);

  typedef struct packed {
    logic [2:0] idx;
    logic       seq_err;
  } entry_t;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] occ;
  logic       first_word;
  logic [2:0] prev_idx;

  logic       push;
  logic       pop;
  logic [2:0] dec_idx;
  logic       dec_err;

  function automatic logic [2:0] decode(input logic [2:0] code);
    logic [2:0] idx;
    case (code)
      3'b111:  idx = 3'd0;
      3'b110:  idx = 3'd1;
      3'b100:  idx = 3'd2;
      3'b101:  idx = 3'd3;
      3'b001:  idx = 3'd4;
      3'b000:  idx = 3'd5;
      3'b010:  idx = 3'd6;
      3'b011:  idx = 3'd7;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    dec_idx = decode(in_code);
    dec_err = 1'b0;
    if (!first_word && (dec_idx != prev_idx + 3'd1)) dec_err = 1'b1;
  end

  // Both flags come straight from the occupancy register: no in_* to out_* path,
  // and a full FIFO refuses a word even when the head is popped the same cycle.
  assign in_ready    = (occ != 2'd2);
  assign out_valid   = (occ != 2'd0);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign out_idx     = mem[rd_ptr].idx;
  assign out_seq_err = mem[rd_ptr].seq_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two storage entries are reset because the head entry is
      // visible on out_idx/out_seq_err even while the FIFO is empty.
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      first_word <= 1'b1;
      prev_idx   <= 3'd0;
      dec_count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{idx: dec_idx, seq_err: dec_err};
        wr_ptr      <= ~wr_ptr;
        prev_idx    <= dec_idx;
        first_word  <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (dec_count != '1) dec_count <= dec_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_code_inv_dec.sv
// Directed bench for code_inv_dec: table-driven decode/sequence streams plus
// hand-written backpressure, mid-stream reset and counter saturation sequences.
module tb_code_inv_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       out_ready;

  logic       in_ready, out_valid, out_seq_err;
  logic [2:0] out_idx;
  logic [7:0] dec_count;

  logic       s_in_ready, s_out_valid, s_out_seq_err;
  logic [2:0] s_out_idx;
  logic [1:0] s_dec_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  code_inv_dec #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_seq_err(out_seq_err), .dec_count(dec_count)
  );

  code_inv_dec #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_code(in_code), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_idx(s_out_idx), .out_seq_err(s_out_seq_err), .dec_count(s_dec_count)
  );

  typedef struct {
    bit         restart;
    logic [2:0] code;
    logic [2:0] idx;
    logic       err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_code = 3'b000;
    step();
    rst = 1'b0;
    check("rst in_ready",    int'(in_ready),    1);
    check("rst out_valid",   int'(out_valid),   0);
    check("rst out_idx",     int'(out_idx),     0);
    check("rst out_seq_err", int'(out_seq_err), 0);
    check("rst dec_count",   int'(dec_count),   0);
  endtask

  task automatic drain(input int pos);
    in_valid = 1'b0;
    step();
    check("drain out_valid", int'(out_valid), 0);
    check("drain dec_count", int'(dec_count), pos);
  endtask

  initial begin
    int pos;
    int exp_sat [5];

    vecs = '{
      // full decode sweep, all in sequence
      '{1'b1, 3'b111, 3'd0, 1'b0}, '{1'b0, 3'b110, 3'd1, 1'b0},
      '{1'b0, 3'b100, 3'd2, 1'b0}, '{1'b0, 3'b101, 3'd3, 1'b0},
      '{1'b0, 3'b001, 3'd4, 1'b0}, '{1'b0, 3'b000, 3'd5, 1'b0},
      '{1'b0, 3'b010, 3'd6, 1'b0}, '{1'b0, 3'b011, 3'd7, 1'b0},
      // skip, resume, repeat (prev_idx tracks erroneous words), resume
      '{1'b1, 3'b111, 3'd0, 1'b0}, '{1'b0, 3'b100, 3'd2, 1'b1},
      '{1'b0, 3'b101, 3'd3, 1'b0}, '{1'b0, 3'b101, 3'd3, 1'b1},
      '{1'b0, 3'b001, 3'd4, 1'b0},
      // 7 -> 0 wraps in sequence, first word after reset has no error
      '{1'b1, 3'b011, 3'd7, 1'b0}, '{1'b0, 3'b111, 3'd0, 1'b0}
    };
    exp_sat = '{1, 2, 3, 3, 3};

    rst = 1'b1; in_valid = 1'b0; in_code = 3'b000; out_ready = 1'b0;

    // Streaming vectors: with out_ready=1 each word is the head one cycle after accept.
    pos = 0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].restart) begin
        if (i > 0) drain(pos);
        do_reset();
        pos = 0;
      end
      in_valid  = 1'b1;
      in_code   = vecs[i].code;
      out_ready = 1'b1;
      step();
      check($sformatf("vec%0d out_valid", i), int'(out_valid),   1);
      check($sformatf("vec%0d out_idx", i),   int'(out_idx),     int'(vecs[i].idx));
      check($sformatf("vec%0d seq_err", i),   int'(out_seq_err), int'(vecs[i].err));
      check($sformatf("vec%0d dec_count", i), int'(dec_count),   pos);
      pos++;
    end
    drain(pos);

    // Backpressure: two words fill the FIFO, third waits until space frees.
    do_reset();
    in_valid = 1'b1; in_code = 3'b111;
    step();
    check("bp1 in_ready", int'(in_ready), 1);
    check("bp1 out_idx",  int'(out_idx),  0);
    in_code = 3'b110;
    step();
    check("bp2 in_ready", int'(in_ready), 0);
    check("bp2 out_idx",  int'(out_idx),  0);
    in_code = 3'b100;
    step();
    check("bp3 in_ready",  int'(in_ready),  0);
    check("bp3 out_idx",   int'(out_idx),   0);
    check("bp3 dec_count", int'(dec_count), 0);
    out_ready = 1'b1;
    step();
    check("bp4 out_idx",   int'(out_idx),   1);
    check("bp4 in_ready",  int'(in_ready),  1);
    check("bp4 dec_count", int'(dec_count), 1);
    step();
    check("bp5 out_idx",   int'(out_idx),     2);
    check("bp5 seq_err",   int'(out_seq_err), 0);
    check("bp5 dec_count", int'(dec_count),   2);
    drain(3);

    // Reset mid-stream, with both handshakes offered during the reset cycle.
    do_reset();
    in_valid = 1'b1; in_code = 3'b010;
    step();
    in_code = 3'b011;
    step();
    check("mid full", int'(in_ready), 0);
    rst = 1'b1; out_ready = 1'b1; in_code = 3'b011;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("mid out_valid", int'(out_valid), 0);
    check("mid in_ready",  int'(in_ready),  1);
    check("mid dec_count", int'(dec_count), 0);
    check("mid out_idx",   int'(out_idx),   0);
    in_valid = 1'b1; in_code = 3'b000;
    step();
    in_valid = 1'b0;
    check("mid idx",     int'(out_idx),     5);
    check("mid seq_err", int'(out_seq_err), 0);
    out_ready = 1'b1;
    step();
    check("mid count", int'(dec_count), 1);
    check("mid empty", int'(out_valid), 0);

    // Saturation on the CNT_W=2 instance: five back-to-back handshakes.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 5);
      in_code  = vecs[k].code;
      step();
      if (k > 0) check($sformatf("sat%0d dec_count", k), int'(s_dec_count), exp_sat[k-1]);
    end
    check("sat main count", int'(dec_count), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
